// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  // A request transfers on a rising edge where req_valid & req_ready & !kill; a response
  // transfers on a rising edge where resp_valid & resp_ready. Once resp_valid rises it and
  // resp_data stay stable until that transfer or a kill.
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            kill;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  modport master (
    output req_valid, req_op, req_a, req_b, kill, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, kill, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle on magnitudes (shift-add / restoring),
// sign fix-up on the way into DONE, result held until the consumer takes it.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus,
  output logic [1:0]   dbg_state_o
);
  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            accept, a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  // Request decode: operand magnitudes, signs and the divide corner cases.
  always_comb begin
    accept   = bus.req_valid && (state_q == S_IDLE) && !bus.kill;
    a_signed = (bus.req_op == OP_MULH) || (bus.req_op == OP_MULHSU) ||
               (bus.req_op == OP_DIV)  || (bus.req_op == OP_REM);
    b_signed = (bus.req_op == OP_MULH) || (bus.req_op == OP_DIV) || (bus.req_op == OP_REM);
    sa       = a_signed && bus.req_a[XLEN-1];
    sb       = b_signed && bus.req_b[XLEN-1];
    abs_a    = sa ? -bus.req_a : bus.req_a;
    abs_b    = sb ? -bus.req_b : bus.req_b;
    div_zero = bus.req_op[2] && (bus.req_b == '0);
    div_ovf  = ((bus.req_op == OP_DIV) || (bus.req_op == OP_REM)) &&
               (bus.req_a == MIN_NEG) && (bus.req_b == '1);
    if (div_zero) special_res = bus.req_op[1] ? bus.req_a : '1;
    else          special_res = bus.req_op[1] ? '0 : bus.req_a;
  end

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    prod_fix  = qneg_q ? -acc_q : acc_q;
    quo_fix   = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      OP_REM, OP_REMU:              final_res = rem_fix;
      default:                      final_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = bus.req_op;
          b_d    = abs_b;
          qneg_d = sa ^ sb;
          rneg_d = sa;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, abs_a};
            cnt_d   = CNT_W'(XLEN);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // The cycle after the last step applies the sign fix and publishes the result.
        if (cnt_q != '0) begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          res_d   = final_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.kill && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.resp_data  = res_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, handshake/kill/reset checks and a random
// sweep on 32- and 16-bit builds against an arithmetic reference model.
module tb_muldiv_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg32, dbg16;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) b32 ();
  muldiv_unit_if #(.XLEN(16)) b16 ();

  muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32), .dbg_state_o(dbg32));
  muldiv_unit #(.XLEN(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16), .dbg_state_o(dbg16));

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics via 64-bit integer arithmetic on width-w operands.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    longint mask, ua, ub, sa, sb, r;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = ((ua >> (w - 1)) & 1) != 0 ? ua - (mask + 1) : ua;
    sb   = ((ub >> (w - 1)) & 1) != 0 ? ub - (mask + 1) : ub;
    case (op)
      3'b000:  r = sa * sb;
      3'b001:  r = (sa * sb) >>> w;
      3'b010:  r = (sa * ub) >>> w;
      3'b011:  r = (ua * ub) >> w;
      3'b100:  r = (ub == 0) ? -1 : sa / sb;
      3'b101:  r = (ub == 0) ? -1 : ua / ub;
      3'b110:  r = (ub == 0) ? sa : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic logic [31:0] pick(input bit w16);
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return w16 ? 32'h0000_8000 : 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input bit w16, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w16) begin
      b16.req_valid = v; b16.req_op = op; b16.req_a = a[15:0]; b16.req_b = b[15:0];
    end else begin
      b32.req_valid = v; b32.req_op = op; b32.req_a = a;       b32.req_b = b;
    end
  endtask

  task automatic set_rr(input bit w16, input logic v);
    if (w16) b16.resp_ready = v;
    else     b32.resp_ready = v;
  endtask

  // Issue one op, check latency and result, optionally stall the response, then take it.
  task automatic run_op(input bit w16, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold,
                        input string tag);
    int          w, lat, exp_lat;
    logic [31:0] mask, minv, am, bm, obs;
    logic        rv, rr;
    w       = w16 ? 16 : 32;
    mask    = w16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    minv    = w16 ? 32'h0000_8000 : 32'h8000_0000;
    am      = a & mask;
    bm      = b & mask;
    exp_lat = (op[2] && (bm == 0 || (!op[0] && am == minv && bm == mask))) ? 1 : w + 1;
    @(negedge clk);
    drive(w16, 1'b1, op, am, bm);
    @(posedge clk); #1;
    drive(w16, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    lat = 0;
    rv  = 1'b0;
    while (!rv && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      rv = w16 ? b16.resp_valid : b32.resp_valid;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    obs = w16 ? {16'h0, b16.resp_data} : b32.resp_data;
    check({tag, " data"}, 64'(obs), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      drive(w16, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
      @(posedge clk); #1;
      rv  = w16 ? b16.resp_valid : b32.resp_valid;
      rr  = w16 ? b16.req_ready  : b32.req_ready;
      obs = w16 ? {16'h0, b16.resp_data} : b32.resp_data;
      check({tag, " hold valid"}, 64'(rv), 64'd1);
      check({tag, " hold data"}, 64'(obs), 64'(exp));
      check({tag, " hold req_ready"}, 64'(rr), 64'd0);
    end
    drive(w16, 1'b0, 3'd0, 32'h0, 32'h0);
    set_rr(w16, 1'b1);
    @(posedge clk); #1;
    set_rr(w16, 1'b0);
    rv  = w16 ? b16.resp_valid : b32.resp_valid;
    rr  = w16 ? b16.req_ready  : b32.req_ready;
    obs = w16 ? {16'h0, b16.resp_data} : b32.resp_data;
    check({tag, " taken valid"}, 64'(rv), 64'd0);
    check({tag, " taken req_ready"}, 64'(rr), 64'd1);
    check({tag, " taken data held"}, 64'(obs), 64'(exp));
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          seen;

    rst_n = 1'b0;
    b32.kill = 1'b0; b32.resp_ready = 1'b0;
    b16.kill = 1'b0; b16.resp_ready = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 64'(b32.req_ready), 64'd1);
    check("reset resp_valid", 64'(b32.resp_valid), 64'd0);
    check("reset resp_data", 64'(b32.resp_data), 64'd0);
    check("reset busy", 64'(b32.busy), 64'd0);
    check("reset16 req_ready", 64'(b16.req_ready), 64'd1);
    check("reset16 busy", 64'(b16.busy), 64'd0);
    rst_n = 1'b1;

    run_op(1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10, "mul 7*-3");
    run_op(1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh min*min");
    run_op(1'b0, 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulhu");
    run_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu -1");
    run_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "div -7/2");
    run_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "rem -7%2");
    run_op(1'b0, 3'b101, 32'd100, 32'd7, 32'd14, 0, "divu 100/7");
    run_op(1'b0, 3'b111, 32'd100, 32'd7, 32'd2, 0, "remu 100%7");
    run_op(1'b0, 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divu by 0");
    run_op(1'b0, 3'b110, 32'd5, 32'd0, 32'd5, 3, "rem by 0");
    run_op(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, "rem ovf");
    run_op(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div ovf");

    // kill during the fifth CALC cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'd5, 32'd6);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    #1 b32.kill = 1'b1;
    @(posedge clk); #1;
    b32.kill = 1'b0;
    check("kill busy", 64'(b32.busy), 64'd0);
    check("kill resp_valid", 64'(b32.resp_valid), 64'd0);
    check("kill req_ready", 64'(b32.req_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b32.resp_valid) seen++;
    end
    check("kill no response", 64'(seen), 64'd0);

    // kill in IDLE blocks the accept
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'd3, 32'd4);
    b32.kill = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    b32.kill = 1'b0;
    check("kill idle busy", 64'(b32.busy), 64'd0);

    // reset during CALC
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b100, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst mid req_ready", 64'(b32.req_ready), 64'd1);
    check("rst mid resp_valid", 64'(b32.resp_valid), 64'd0);
    check("rst mid resp_data", 64'(b32.resp_data), 64'd0);
    check("rst mid busy", 64'(b32.busy), 64'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b32.resp_valid) seen++;
    end
    check("rst mid no response", 64'(seen), 64'd0);

    for (int i = 0; i < 800; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick(1'b0);
      b  = pick(1'b0);
      run_op(1'b0, op, a, b, ref_model(op, a, b, 32), 0, "rand32");
    end
    for (int i = 0; i < 500; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick(1'b1);
      b  = pick(1'b1);
      run_op(1'b1, op, a, b, ref_model(op, a, b, 16), 0, "rand16");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
